multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control unit that sequences the 8-bit register-file/ALU datapath.
- Fetches 32-bit RV32I-subset instructions through a request/valid instruction port and decodes them.
- Drives datapath control (register indices, immediate, ALU op, write strobes, link value) over FETCH/DECODE/EXECUTE/MEMORY states.
- Owns the program counter and a data-memory request handshake.

Parameters:
- NBITS, 8, datapath and PC width
- NREGS, 32, register count; register index width is $clog2(NREGS)
- WIDTH_ALUF, 4, ALUControl width

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- instr_addr  output  NBITS  current PC
- instr_req  output  1  fetch request
- instr_valid  input  1  instr is valid this cycle
- instr  input  32  instruction word
- RS1, RS2, RD  output  $clog2(NREGS)  register indices (from latched IR)
- IMM  output  NBITS  sign-extended immediate, truncated to NBITS
- ALUControl  output  WIDTH_ALUF  ADD=4'b0000, SUB=4'b1000
- ALUSrc  output  1  1 selects IMM as SrcB
- MemtoReg  output  1  writeback from ReadData
- RegWrite  output  1  register write strobe
- link  output  1  writeback from pclink
- pclink  output  NBITS  PC+4 of the current instruction
- Zero, Neg, Carry  input  1  ALU flags; only Zero is used
- PCReg  input  NBITS  rs1 value, used by JALR
- mem_req  output  1  data-memory access request
- mem_we  output  1  store when mem_req=1
- mem_ready  input  1  access complete
- halted  output  1  illegal instruction trapped
- state_dbg  output  3  encoded FSM state

Behaviour:
- Reset (async, any state):
  - PC=0, IR=0, state=FETCH, halted=0.
  - All strobes (instr_req, RegWrite, mem_req, mem_we, link, MemtoReg, ALUSrc) are 0; ALUControl=ADD.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
- FETCH:
  - instr_req=1, instr_addr=PC.
  - When instr_valid=1, IR<=instr and state goes to DECODE next cycle; otherwise stay.
  - instr_valid outside FETCH is ignored.
- DECODE (1 cycle):
  - Fields come from IR: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
  - IMM is formatted per opcode (I/S/B/J).
  - Supported: ADD, SUB (0110011, funct7 bit30 selects SUB); ADDI (0010011, funct3=000); LW (0000011, funct3=010); SW (0100011, funct3=010); BEQ/BNE (1100011, funct3 000/001); JAL (1101111); JALR (1100111).
  - Any other encoding goes to HALT.
- EXEC (1 cycle, no strobes in DECODE):
  - ADD/SUB/ADDI: RegWrite=1 (ALUSrc=1 for ADDI); PC<=PC+4; next FETCH.
  - LW/SW: ALUSrc=1, ALUControl=ADD; next MEM.
  - BEQ/BNE: ALUControl=SUB, ALUSrc=0. Branch is taken if (Zero XOR BNE): PC<=PC+IMM; else PC<=PC+4. No RegWrite. Next FETCH.
  - JAL: link=1, RegWrite=1, pclink=PC+4; PC<=PC+IMM.
  - JALR: link=1, RegWrite=1, pclink=PC+4; PC<=(PCReg+IMM)&~1.
- MEM:
  - mem_req=1 is held with address/ALU controls held; mem_we=1 for SW.
  - On the cycle mem_ready=1: for LW, RegWrite=1 and MemtoReg=1 that same cycle. Then PC<=PC+4 and next FETCH.
  - mem_ready already high on MEM entry completes in that one cycle.
- HALT: sticky until reset. halted=1; no requests or strobes.
- PC arithmetic is modulo 2^NBITS (0xFC+4=0x00). IMM is taken as the low NBITS of the sign-extended immediate.
- RegWrite is asserted for exactly one cycle per writing instruction. Writes with rd=x0 are still issued; the datapath discards them.
- Latency with zero-wait memories:
  - ALU/branch/jump: 3 cycles.
  - Load/store: 4 cycles.
  - Each wait cycle on instr_valid or mem_ready adds one cycle.
- Reset asserted mid-MEM drops mem_req asynchronously. No partial writeback occurs.

Test Plan:
- Reset, then FETCH with instr_valid=1, instr=0x00500093 (ADDI x1,x0,5) -> DECODE, then EXEC with RS1=0, RD=1, IMM=5, ALUSrc=1, RegWrite=1 for one cycle; PC 0->4; next fetch at 0x04.
- instr=0x00000463 (BEQ x0,x0,+8) at PC=0x04 with Zero=1 -> PC=0x0C, RegWrite=0. Same word with Zero=0 -> PC=0x08.
- instr=0x010000EF (JAL x1,+16) at PC=0x10 -> link=1, RegWrite=1, RD=1, pclink=0x14, PC=0x20.
- LW with mem_ready held low 3 cycles -> mem_req=1 and mem_we=0 for 4 cycles; RegWrite=1 and MemtoReg=1 only in the mem_ready cycle.
- SW at PC=0xFC -> mem_we=1 while mem_req=1, RegWrite never set; PC wraps to 0x00.
- instr=0x00000000 -> HALT, halted=1, instr_req stays 0. Reset asserted mid-MEM -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM sequencer for an RV32I-subset core
// driving an NBITS register-file/ALU datapath with request/valid instruction and data ports.
module multicycle_controller #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [NBITS-1:0]      instr_addr,
    output logic                  instr_req,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic [RW-1:0]         RS1,
    output logic [RW-1:0]         RS2,
    output logic [RW-1:0]         RD,
    output logic [NBITS-1:0]      IMM,
    output logic [WIDTH_ALUF-1:0] ALUControl,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  link,
    output logic [NBITS-1:0]      pclink,
    input  logic                  Zero,
    input  logic                  Neg,
    input  logic                  Carry,
    input  logic [NBITS-1:0]      PCReg,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, HALT = 3'd4} state_t;

    localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(4'b0000);
    localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);

    state_t           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r, is_sub, is_addi, is_lw, is_sw, is_br, is_bne, is_jal, is_jalr, legal;
    logic [31:0] imm32;
    logic [NBITS-1:0] pc_plus4, pc_plus_imm, jalr_tgt;
    logic        unused_flags;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign is_r    = opcode == 7'b0110011 && funct3 == 3'b000 && (ir_q[31:25] & 7'b1011111) == 7'd0;
    assign is_sub  = is_r && ir_q[30];
    assign is_addi = opcode == 7'b0010011 && funct3 == 3'b000;
    assign is_lw   = opcode == 7'b0000011 && funct3 == 3'b010;
    assign is_sw   = opcode == 7'b0100011 && funct3 == 3'b010;
    assign is_br   = opcode == 7'b1100011 && funct3[2:1] == 2'b00;
    assign is_bne  = funct3[0];
    assign is_jal  = opcode == 7'b1101111;
    assign is_jalr = opcode == 7'b1100111;
    assign legal   = is_r | is_addi | is_lw | is_sw | is_br | is_jal | is_jalr;

    always_comb begin
        imm32 = 32'd0;
        if (is_addi || is_lw || is_jalr) imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
        else if (is_sw)                  imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_br)                  imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        else if (is_jal)                 imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    end

    assign IMM         = imm32[NBITS-1:0];
    assign RS1         = RW'(ir_q[19:15]);
    assign RS2         = RW'(ir_q[24:20]);
    assign RD          = RW'(ir_q[11:7]);
    assign pc_plus4    = pc_q + NBITS'(4);
    assign pc_plus_imm = pc_q + IMM;
    assign jalr_tgt    = (PCReg + IMM) & ~NBITS'(1);
    assign pclink      = pc_plus4;
    assign instr_addr  = pc_q;
    assign state_dbg   = state_q;
    // Only Zero participates in branch resolution.
    assign unused_flags = Neg ^ Carry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                ir_d    = instr_valid ? instr : ir_q;
                state_d = instr_valid ? DECODE : FETCH;
            end
            DECODE: state_d = legal ? EXEC : HALT;
            EXEC: begin
                state_d = (is_lw || is_sw) ? MEM : FETCH;
                if (is_r || is_addi) pc_d = pc_plus4;
                else if (is_br)      pc_d = (Zero ^ is_bne) ? pc_plus_imm : pc_plus4;
                else if (is_jal)     pc_d = pc_plus_imm;
                else if (is_jalr)    pc_d = jalr_tgt;
            end
            MEM: begin
                state_d = mem_ready ? FETCH : MEM;
                pc_d    = mem_ready ? pc_plus4 : pc_q;
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        instr_req  = 1'b0;
        ALUControl = ALU_ADD;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        link       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            // Gated so outputs read as reset values while reset is held.
            FETCH: instr_req = ~reset;
            EXEC: begin
                ALUControl = (is_br || is_sub) ? ALU_SUB : ALU_ADD;
                ALUSrc     = is_addi | is_lw | is_sw;
                RegWrite   = is_r | is_addi | is_jal | is_jalr;
                link       = is_jal | is_jalr;
            end
            MEM: begin
                ALUSrc   = 1'b1;
                mem_req  = 1'b1;
                mem_we   = is_sw;
                RegWrite = is_lw & mem_ready;
                MemtoReg = is_lw & mem_ready;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed program walk through the controller with hand-computed expectations.
module tb_multicycle_controller;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instr_addr;
    logic       instr_req;
    logic       instr_valid;
    logic [31:0] instr;
    logic [4:0] RS1, RS2, RD;
    logic [7:0] IMM;
    logic [3:0] ALUControl;
    logic       ALUSrc, MemtoReg, RegWrite, link;
    logic [7:0] pclink;
    logic       Zero, Neg, Carry;
    logic [7:0] PCReg;
    logic       mem_req, mem_we, mem_ready, halted;
    logic [2:0] state_dbg;

    int total = 0;
    int passed = 0;

    multicycle_controller dut (
        .clock(clock), .reset(reset), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_valid(instr_valid), .instr(instr), .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .link(link), .pclink(pclink), .Zero(Zero), .Neg(Neg), .Carry(Carry), .PCReg(PCReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .halted(halted),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic fetch(input logic [31:0] w);
        instr_valid = 1'b1;
        instr = w;
        tick();
        instr_valid = 1'b0;
        instr = 32'hDEAD_BEEF;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; Zero = 1'b0; Neg = 1'b0;
        Carry = 1'b0; PCReg = 8'h0; mem_ready = 1'b0;
        tick(); tick();
        check("rst_instr_req", instr_req, 0);
        check("rst_state", state_dbg, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", instr_addr, 8'h00);
        check("rst_regwrite", RegWrite, 0);
        check("rst_aluctl", ALUControl, 4'b0000);
        reset = 1'b0;
        #1;
        check("fetch_req", instr_req, 1);
        tick();
        // ADDI x1,x0,5 at 0x00
        fetch(32'h00500093);
        check("addi_decode_state", state_dbg, 1);
        check("addi_decode_regwrite", RegWrite, 0);
        check("addi_rs1", RS1, 0);
        check("addi_rd", RD, 1);
        check("addi_imm", IMM, 8'd5);
        tick();
        check("addi_exec_state", state_dbg, 2);
        check("addi_regwrite", RegWrite, 1);
        check("addi_alusrc", ALUSrc, 1);
        tick();
        check("addi_back_fetch", state_dbg, 0);
        check("addi_regwrite_once", RegWrite, 0);
        check("addi_pc", instr_addr, 8'h04);
        // BEQ x0,x0,+8 taken at 0x04
        Zero = 1'b1;
        fetch(32'h00000463);
        check("beq_imm", IMM, 8'd8);
        tick();
        check("beq_aluctl", ALUControl, 4'b1000);
        check("beq_alusrc", ALUSrc, 0);
        check("beq_regwrite", RegWrite, 0);
        tick();
        check("beq_taken_pc", instr_addr, 8'h0C);
        // same BEQ not taken at 0x0C
        Zero = 1'b0;
        fetch(32'h00000463);
        tick(); tick();
        check("beq_not_taken_pc", instr_addr, 8'h10);
        // JAL x1,+16 at 0x10
        fetch(32'h010000EF);
        tick();
        check("jal_link", link, 1);
        check("jal_regwrite", RegWrite, 1);
        check("jal_rd", RD, 1);
        check("jal_pclink", pclink, 8'h14);
        tick();
        check("jal_pc", instr_addr, 8'h20);
        check("jal_link_drop", link, 0);
        // LW x2,4(x1) at 0x20 with three wait cycles
        fetch(32'h0040A103);
        check("lw_imm", IMM, 8'd4);
        tick();
        check("lw_exec_alusrc", ALUSrc, 1);
        check("lw_exec_no_memreq", mem_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lw_wait%0d_memreq", i), mem_req, 1);
            check($sformatf("lw_wait%0d_we", i), mem_we, 0);
            check($sformatf("lw_wait%0d_regwrite", i), RegWrite, 0);
        end
        mem_ready = 1'b1;
        #1;
        check("lw_ready_memreq", mem_req, 1);
        check("lw_ready_regwrite", RegWrite, 1);
        check("lw_ready_memtoreg", MemtoReg, 1);
        tick();
        mem_ready = 1'b0;
        check("lw_pc", instr_addr, 8'h24);
        check("lw_regwrite_drop", RegWrite, 0);
        // JALR x0,0(x5) at 0x24 with rs1 value 0xFD -> 0xFC
        PCReg = 8'hFD;
        fetch(32'h00028067);
        tick();
        check("jalr_link", link, 1);
        check("jalr_regwrite_x0", RegWrite, 1);
        check("jalr_pclink", pclink, 8'h28);
        tick();
        check("jalr_pc", instr_addr, 8'hFC);
        // SW x2,8(x1) at 0xFC, memory ready on entry
        fetch(32'h0020A423);
        check("sw_imm", IMM, 8'd8);
        mem_ready = 1'b1;
        tick();
        check("sw_exec_regwrite", RegWrite, 0);
        tick();
        check("sw_memreq", mem_req, 1);
        check("sw_we", mem_we, 1);
        check("sw_regwrite", RegWrite, 0);
        tick();
        mem_ready = 1'b0;
        check("sw_pc_wrap", instr_addr, 8'h00);
        check("sw_state", state_dbg, 0);
        // LW interrupted by reset while in MEM
        fetch(32'h0040A103);
        tick(); tick();
        check("lw2_in_mem", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_memreq", mem_req, 0);
        check("arst_state", state_dbg, 0);
        check("arst_instr_req", instr_req, 0);
        check("arst_rd", RD, 0);
        check("arst_regwrite", RegWrite, 0);
        tick();
        reset = 1'b0;
        tick();
        // illegal all-zero word traps
        fetch(32'h00000000);
        tick();
        check("halt_state", state_dbg, 4);
        check("halt_flag", halted, 1);
        instr_valid = 1'b1;
        tick(); tick();
        check("halt_sticky", halted, 1);
        check("halt_no_req", instr_req, 0);
        check("halt_pc", instr_addr, 8'h00);
        instr_valid = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
